conv_output_packer: RTL and testbench
=====================================

CONV_OUTPUT_PACKER -- requirements
Module: conv_output_packer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the result and stream word width.
REQ-002 SHALL have parameter KERNEL_SIZE, default 3, meaning the convolution kernel edge length used for the output count.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16 (power of 2, at least 4), meaning the result buffer entries.
REQ-004 SHALL have parameter AFULL_MARGIN, default 4, meaning the free entries at which backpressure asserts.
REQ-005 Ports, name/direction/width/meaning:
- axi_clk  in  1  the single clock; all logic on its rising edge.
- axi_reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  run enable from the control register.
- soft_clr  in  1  synchronous clear pulse from the reset register.
- cfg_width, cfg_height  in  16 each  image dimensions in pixels.
- cSum  in  DATA_WIDTH  accelerator accumulated result.
- cReady  in  1  accelerator result-ready level.
- acc_hold  out  1  backpressure to the convolution controller.
- m_axis_data  out  DATA_WIDTH  output stream data.
- m_axis_valid  out  1  output stream valid.
- m_axis_ready  in  1  output stream ready.
- m_axis_last  out  1  last word of frame.
- m_axis_keep  out  4  byte enables.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied entries.
- overflow  out  1  sticky drop flag.
- cfg_err  out  1  invalid dimensions.
- frame_done  out  1  single-cycle end-of-frame pulse.

Function
REQ-006 Capture SHALL occur on the cReady rising edge: cReady=1 in the current cycle and 0 in the previous cycle. The registered cSum is written to the FIFO at the next edge. A cReady level held high SHALL capture only once.
REQ-007 Results per frame SHALL be N=(cfg_width-KERNEL_SIZE+1)*(cfg_height-KERNEL_SIZE+1), computed in 32 bits and latched on entry to RUN.
REQ-008 The FSM SHALL have three states: IDLE, RUN and DONE.
- IDLE->RUN when enable=1, cfg_width>=KERNEL_SIZE and cfg_height>=KERNEL_SIZE.
- RUN->DONE on the handshake of the word carrying last.
- DONE->RUN after one cycle if enable=1, otherwise DONE->IDLE.
REQ-009 In IDLE with enable=1 and invalid dimensions, cfg_err SHALL be 1 and the FSM SHALL stay in IDLE. Otherwise cfg_err SHALL be 0.
REQ-010 Captures SHALL be ignored outside RUN.
REQ-011 A capture counter SHALL increment on every RUN capture. The capture with counter==N-1 SHALL be tagged last, and the counter SHALL then return to 0.
REQ-012 The FIFO SHALL store {last, data} and be first-word fall-through. With the FIFO empty, m_axis_valid SHALL assert in the cycle after the capture cycle, so latency is 1 cycle from capture to valid.
REQ-013 The output SHALL follow AXI4-Stream:
- a word is transferred when m_axis_valid and m_axis_ready are both 1;
- data, last and keep SHALL stay stable while valid=1 and ready=0;
- m_axis_keep SHALL be 4'hf whenever valid=1, otherwise 0.
REQ-014 A simultaneous write and read SHALL be permitted at any level, including full, with fifo_level unchanged.
REQ-015 A capture with the FIFO full and no read in the same cycle SHALL be dropped and SHALL set overflow. The counter still advances. If the dropped word was tagged last, no last is emitted and the FSM SHALL go RUN->DONE directly.
REQ-016 acc_hold SHALL be 1 when fifo_level >= FIFO_DEPTH-AFULL_MARGIN.
REQ-017 frame_done SHALL pulse for exactly the one cycle spent in DONE.
REQ-018 Read and write pointers SHALL wrap modulo FIFO_DEPTH. fifo_level SHALL reach FIFO_DEPTH at full.
REQ-019 enable deasserting mid-frame SHALL NOT abort the frame. The FSM SHALL finish the frame through DONE to IDLE.

Reset
REQ-020 axi_reset_n=0 SHALL asynchronously set FSM=IDLE and clear the pointers, counter and edge register. All outputs SHALL go to 0: m_axis_valid, m_axis_last, m_axis_keep, m_axis_data, fifo_level, overflow, cfg_err, frame_done and acc_hold.
REQ-021 soft_clr=1 SHALL apply the same clearing synchronously at the next edge. It SHALL take priority over a simultaneous capture or read.

Configuration
REQ-022 Macro CONV_OUT_RELU_EN:
- when defined, a captured cSum with MSB=1 (signed negative) SHALL be written as 0;
- when undefined, cSum SHALL be written unmodified.
Counting, tagging and timing SHALL be identical in both builds.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- 8x8 frame, K=3, 36 captures of values 0..35, ready=1 -> 36 words 0..35 in order; last only on 35; frame_done pulses once.
- ready=0 for 20 captures, DEPTH=16 -> acc_hold=1 at level 12; 4 drops; overflow=1; 16 words out after ready=1.
- cReady held high 5 cycles with cSum=7 -> exactly one word 7.
- cfg_width=2, enable=1 -> cfg_err=1, FSM in IDLE, captures ignored.
- Capture of 32'hFFFFFFF0 -> outputs 0 with CONV_OUT_RELU_EN, 32'hFFFFFFF0 without.
- axi_reset_n=0 mid-frame with 5 words queued -> all outputs 0 immediately; next frame starts at counter 0.

Source files
------------

// File: rtl/conv_output_packer.sv
// conv_output_packer: packs accelerator results into an AXI4-Stream frame.
// Captures cSum on each cReady rising edge during RUN, buffers {last,data}
// in a first-word fall-through FIFO and tags the Nth result of a frame.
// Ports: axi_clk/axi_reset_n clock and async active-low reset; enable and
// soft_clr control; cfg_width/cfg_height image size; cSum/cReady result in;
// acc_hold backpressure; m_axis_* stream out; fifo_level, overflow,
// cfg_err, frame_done status.
// Build option: CONV_OUT_RELU_EN writes negative results as zero.
module conv_output_packer #(
  parameter int DATA_WIDTH   = 32,
  parameter int KERNEL_SIZE  = 3,
  parameter int FIFO_DEPTH   = 16,
  parameter int AFULL_MARGIN = 4
) (
  input  logic                          axi_clk,
  input  logic                          axi_reset_n,
  input  logic                          enable,
  input  logic                          soft_clr,
  input  logic [15:0]                   cfg_width,
  input  logic [15:0]                   cfg_height,
  input  logic [DATA_WIDTH-1:0]         cSum,
  input  logic                          cReady,
  output logic                          acc_hold,
  output logic [DATA_WIDTH-1:0]         m_axis_data,
  output logic                          m_axis_valid,
  input  logic                          m_axis_ready,
  output logic                          m_axis_last,
  output logic [3:0]                    m_axis_keep,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          cfg_err,
  output logic                          frame_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [15:0] K16 = 16'(KERNEL_SIZE);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic                  cready_q;
  logic [LW-1:0]         wr_ptr, rd_ptr;
  logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];
  logic [DATA_WIDTH:0]   head;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [31:0]           cnt, n_res, n_calc;
  logic [15:0]           w_out, h_out;
  logic                  dims_ok;
  logic                  capture, wr_req, wr_en, rd_en;
  logic                  full, drop, tag;

  assign dims_ok = (cfg_width >= K16) && (cfg_height >= K16);
  assign w_out   = cfg_width - K16 + 16'd1;
  assign h_out   = cfg_height - K16 + 16'd1;
  assign n_calc  = 32'(w_out) * 32'(h_out);

  assign fifo_level   = wr_ptr - rd_ptr;
  assign full         = fifo_level == LW'(FIFO_DEPTH);
  assign m_axis_valid = fifo_level != '0;
  assign head         = mem[rd_ptr[AW-1:0]];
  assign m_axis_data  = m_axis_valid ? head[DATA_WIDTH-1:0] : '0;
  assign m_axis_last  = m_axis_valid & head[DATA_WIDTH];
  assign m_axis_keep  = m_axis_valid ? 4'hf : 4'h0;
  assign acc_hold     = fifo_level >= LW'(FIFO_DEPTH - AFULL_MARGIN);

  assign capture = cReady & ~cready_q;
  assign wr_req  = capture & (state == RUN);
  assign rd_en   = m_axis_valid & m_axis_ready;
  // A read in the same cycle frees the slot, so full+read still writes.
  assign wr_en   = wr_req & (~full | rd_en);
  assign drop    = wr_req & full & ~rd_en;
  assign tag     = cnt == (n_res - 32'd1);

  assign frame_done = state == DONE;
  assign cfg_err    = axi_reset_n & (state == IDLE)
                    & enable & ~dims_ok;

`ifdef CONV_OUT_RELU_EN
  assign wr_data = cSum[DATA_WIDTH-1] ? '0 : cSum;
`else
  assign wr_data = cSum;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (enable && dims_ok) state_nxt = RUN;
      // A dropped last word can never be read, so finish on the drop.
      RUN:  if ((rd_en && m_axis_last) || (drop && tag))
              state_nxt = DONE;
      DONE: state_nxt = enable ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state    <= IDLE;
      cready_q <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      n_res    <= '0;
      overflow <= 1'b0;
    end else if (soft_clr) begin
      state    <= IDLE;
      cready_q <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      n_res    <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      cready_q <= cReady;
      if (wr_en) wr_ptr <= wr_ptr + LW'(1);
      if (rd_en) rd_ptr <= rd_ptr + LW'(1);
      if (drop) overflow <= 1'b1;
      if (wr_req) cnt <= tag ? '0 : cnt + 32'd1;
      if (state_nxt == RUN && state != RUN) n_res <= n_calc;
    end
  end

  always_ff @(posedge axi_clk) begin
    if (wr_en && !soft_clr)
      mem[wr_ptr[AW-1:0]] <= {tag, wr_data};
  end

endmodule

// File: tb/tb_conv_output_packer.sv
// tb_conv_output_packer: random + directed bench for conv_output_packer.
// Queue-based frame model predicts stream words, level and status flags.
module tb_conv_output_packer;

  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_DONE = 2;

  logic        axi_clk = 1'b0;
  logic        axi_reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        soft_clr = 1'b0;
  logic [15:0] cfg_width = 16'd8;
  logic [15:0] cfg_height = 16'd8;
  logic [31:0] cSum = '0;
  logic        cReady = 1'b0;
  logic        acc_hold;
  logic [31:0] m_axis_data;
  logic        m_axis_valid;
  logic        m_axis_ready = 1'b1;
  logic        m_axis_last;
  logic [3:0]  m_axis_keep;
  logic [4:0]  fifo_level;
  logic        overflow;
  logic        cfg_err;
  logic        frame_done;

  conv_output_packer dut (
    .axi_clk      (axi_clk),
    .axi_reset_n  (axi_reset_n),
    .enable       (enable),
    .soft_clr     (soft_clr),
    .cfg_width    (cfg_width),
    .cfg_height   (cfg_height),
    .cSum         (cSum),
    .cReady       (cReady),
    .acc_hold     (acc_hold),
    .m_axis_data  (m_axis_data),
    .m_axis_valid (m_axis_valid),
    .m_axis_ready (m_axis_ready),
    .m_axis_last  (m_axis_last),
    .m_axis_keep  (m_axis_keep),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .cfg_err      (cfg_err),
    .frame_done   (frame_done)
  );

  always #5 axi_clk = ~axi_clk;

  typedef struct {
    bit          last;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  int          st;
  longint      cnt;
  longint      n;
  bit          prev;
  bit          ovf;
  int          hs;
  int          lasts;
  int          fds;
  int          vectors;
  int          errors;

  task automatic check(string tag, logic [63:0] obs,
                       logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit dims_ok();
    return cfg_width >= 16'd3 && cfg_height >= 16'd3;
  endfunction

  function automatic logic [31:0] relu(logic [31:0] v);
`ifdef CONV_OUT_RELU_EN
    return v[31] ? 32'd0 : v;
`else
    return v;
`endif
  endfunction

  task automatic model_clear();
    q.delete();
    st   = S_IDLE;
    cnt  = 0;
    prev = 0;
    ovf  = 0;
  endtask

  task automatic compare();
    bit v;
    v = q.size() > 0;
    check("valid", 64'(m_axis_valid), 64'(v));
    check("keep", 64'(m_axis_keep), v ? 64'hf : 64'h0);
    check("data", 64'(m_axis_data), v ? 64'(q[0].d) : 64'h0);
    check("last", 64'(m_axis_last), v ? 64'(q[0].last) : 64'h0);
    check("level", 64'(fifo_level), 64'(q.size()));
    check("hold", 64'(acc_hold), 64'(q.size() >= 12));
    check("overflow", 64'(overflow), 64'(ovf));
    check("cfg_err", 64'(cfg_err),
          64'(axi_reset_n && st == S_IDLE && enable && !dims_ok()));
    check("frame_done", 64'(frame_done), 64'(st == S_DONE));
  endtask

  task automatic step();
    bit cap, wr, tag, drop, rd, lastrd;
    ent_t e;
    @(posedge axi_clk);
    if (soft_clr) begin
      model_clear();
    end else begin
      if (st == S_DONE) fds++;
      cap    = cReady && !prev;
      rd     = q.size() > 0 && m_axis_ready;
      lastrd = rd && q[0].last;
      wr     = st == S_RUN && cap;
      tag    = wr && (cnt == n - 1);
      drop   = wr && q.size() == 16 && !rd;
      if (rd) begin
        hs++;
        if (q[0].last) lasts++;
        void'(q.pop_front());
      end
      if (wr && !drop) begin
        e.last = tag;
        e.d    = relu(cSum);
        q.push_back(e);
      end
      if (drop) ovf = 1;
      if (wr) cnt = tag ? 0 : cnt + 1;
      case (st)
        S_IDLE: if (enable && dims_ok()) begin
          st = S_RUN;
          n  = longint'(cfg_width - 2) * longint'(cfg_height - 2);
        end
        S_RUN: if (lastrd || (tag && drop)) st = S_DONE;
        default: begin
          st = enable ? S_RUN : S_IDLE;
          if (enable)
            n = longint'(cfg_width - 2) * longint'(cfg_height - 2);
        end
      endcase
      prev = cReady;
    end
    #1;
    compare();
  endtask

  task automatic cap(logic [31:0] v);
    cSum   = v;
    cReady = 1'b1;
    step();
    cReady = 1'b0;
    step();
  endtask

  task automatic clr();
    enable   = 1'b0;
    soft_clr = 1'b1;
    step();
    soft_clr = 1'b0;
    step();
  endtask

  task automatic hard_reset();
    axi_reset_n = 1'b0;
    #1;
    model_clear();
    compare();
    @(posedge axi_clk);
    #1;
    axi_reset_n = 1'b1;
  endtask

  int hs0, lasts0, fds0;
  logic [31:0] neg;

  initial begin
    st = S_IDLE; cnt = 0; n = 0; prev = 0; ovf = 0;
    hs = 0; lasts = 0; fds = 0; vectors = 0; errors = 0;
    hard_reset();

    // 8x8 frame, 36 results streamed straight through
    enable = 1'b1; cfg_width = 16'd8; cfg_height = 16'd8;
    m_axis_ready = 1'b1;
    step();
    hs0 = hs; lasts0 = lasts; fds0 = fds;
    for (int i = 0; i < 36; i++) cap(32'(i));
    for (int i = 0; i < 4; i++) step();
    check("s1_words", 64'(hs - hs0), 64'd36);
    check("s1_lasts", 64'(lasts - lasts0), 64'd1);
    check("s1_done", 64'(fds - fds0), 64'd1);
    clr();

    // stalled sink, 20 captures into a 16-deep buffer
    enable = 1'b1; m_axis_ready = 1'b0;
    step();
    for (int i = 0; i < 20; i++) cap(32'(100 + i));
    check("s2_level", 64'(fifo_level), 64'd16);
    check("s2_ovf", 64'(overflow), 64'd1);
    hs0 = hs;
    m_axis_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check("s2_words", 64'(hs - hs0), 64'd16);
    clr();

    // cReady held high captures once
    enable = 1'b1;
    step();
    hs0 = hs;
    cSum = 32'd7; cReady = 1'b1;
    for (int i = 0; i < 5; i++) step();
    cReady = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("s3_words", 64'(hs - hs0), 64'd1);
    clr();

    // invalid width
    enable = 1'b1; cfg_width = 16'd2;
    step(); step();
    check("s4_cfg_err", 64'(cfg_err), 64'd1);
    hs0 = hs;
    for (int i = 0; i < 3; i++) cap(32'(i + 50));
    check("s4_words", 64'(hs - hs0), 64'd0);
    check("s4_level", 64'(fifo_level), 64'd0);
    clr();

    // negative result
    cfg_width = 16'd8; enable = 1'b1; m_axis_ready = 1'b0;
    step();
    neg = 32'hFFFF_FFF0;
    cap(neg);
    check("s5_data", 64'(m_axis_data), 64'(relu(neg)));
    m_axis_ready = 1'b1;
    step(); step();
    clr();

    // async reset with words queued, then a fresh 3x4 frame
    enable = 1'b1; m_axis_ready = 1'b0;
    step();
    for (int i = 0; i < 5; i++) cap(32'(200 + i));
    check("s6_level", 64'(fifo_level), 64'd5);
    hard_reset();
    cfg_width = 16'd3; cfg_height = 16'd4; m_axis_ready = 1'b1;
    step();
    lasts0 = lasts; hs0 = hs;
    cap(32'd11);
    cap(32'd22);
    step(); step();
    check("s6_words", 64'(hs - hs0), 64'd2);
    check("s6_lasts", 64'(lasts - lasts0), 64'd1);
    clr();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        cfg_width  = 16'($urandom_range(2, 6));
        cfg_height = 16'($urandom_range(2, 6));
      end
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      if ($urandom_range(0, 9) != 0 && i < 40) enable = 1'b1;
      soft_clr     = $urandom_range(0, 299) == 0;
      cReady       = $urandom_range(0, 2) == 0;
      cSum         = $urandom;
      m_axis_ready = (i / 200) % 3 == 2 ?
                     ($urandom_range(0, 9) == 0) :
                     ($urandom_range(0, 3) != 0);
      step();
    end
    soft_clr = 1'b0;
    cReady = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
